// File: rtl/signed_cmp_pkg.sv
// -----------------------------------------------------------------------------
// signed_cmp_pkg
//
// Shared definitions for the serial signed comparators (GEQ today, LT/LE later).
//   cmp_state_e   : operation FSM states (IDLE, RUN, DONE)
//   CMP_WIDTH     : default operand width
//   CMP_DIGIT     : default bits consumed per cycle
//   CMP_MAX_WIDTH : widest operand sign_flip() can handle
//   sign_flip()   : inverts bit (width-1) so unsigned order equals signed order
// -----------------------------------------------------------------------------
package signed_cmp_pkg;

  localparam int CMP_WIDTH     = 32;
  localparam int CMP_DIGIT     = 4;
  localparam int CMP_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  // Operands narrower than CMP_MAX_WIDTH are zero-extended by the caller and
  // truncated back afterwards; only bit (width-1) is inverted.
  function automatic logic [CMP_MAX_WIDTH-1:0] sign_flip(
    input logic [CMP_MAX_WIDTH-1:0] vec,
    input int unsigned              width
  );
    return vec ^ (CMP_MAX_WIDTH'(1) << (width - 1));
  endfunction

endpackage : signed_cmp_pkg

// File: rtl/signed_geq_serial_digit_cmp.sv
// -----------------------------------------------------------------------------
// digit_cmp
//
// Combinational unsigned magnitude compare of one DIGIT-wide digit pair.
//   da, db : digit of operand A / operand B (sign already flipped upstream)
//   gt     : 1 iff da > db
//   lt     : 1 iff da < db
// Both low means the digits are equal.
// -----------------------------------------------------------------------------
module digit_cmp #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] da,
  input  logic [DIGIT-1:0] db,
  output logic             gt,
  output logic             lt
);

  assign gt = (da > db);
  assign lt = (da < db);

endmodule : digit_cmp

// File: rtl/signed_geq_serial.sv
// -----------------------------------------------------------------------------
// signed_geq_serial
//
// Digit-serial signed A >= B comparator with valid/ready on input and result.
// Operands are captured on the accepting edge with their sign bits inverted,
// then scanned LSB-first DIGIT bits per cycle. A running verdict is kept; a
// differing digit overrides it, since more significant digits arrive later.
// The result appears NDIG edges after acceptance and is held until taken.
//
// Parameters: WIDTH (>= 2, <= CMP_MAX_WIDTH), DIGIT (divides WIDTH).
// Optional build macro SIGNED_GEQ_EQ_OUT_EN adds the 'eq' output (a == b).
//
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b                 : two's-complement operands
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   geq                  : signed(a) >= signed(b), valid while out_valid
//   busy                 : operation in flight (state != IDLE)
//   eq                   : (macro only) a == b, same timing as geq
// -----------------------------------------------------------------------------
module signed_geq_serial
  import signed_cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH,
  parameter int DIGIT = CMP_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             geq,
  output logic             busy
`ifdef SIGNED_GEQ_EQ_OUT_EN
  ,
  output logic             eq
`endif
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

  cmp_state_e       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             geq_q, geq_d;

  logic             dig_gt, dig_lt;
  logic             flag_upd;

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .da (sa_q[DIGIT-1:0]),
    .db (sb_q[DIGIT-1:0]),
    .gt (dig_gt),
    .lt (dig_lt)
  );

  // Equal digits leave the verdict of the less significant digits in place.
  assign flag_upd = dig_gt ? 1'b1 : (dig_lt ? 1'b0 : flag_q);

`ifdef SIGNED_GEQ_EQ_OUT_EN
  logic all_eq_q, all_eq_d;
  logic eq_q, eq_d;
  logic all_eq_upd;

  assign all_eq_upd = all_eq_q & ~(dig_gt | dig_lt);
`endif

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    geq_d   = geq_q;
`ifdef SIGNED_GEQ_EQ_OUT_EN
    all_eq_d = all_eq_q;
    eq_d     = eq_q;
`endif

    unique case (state_q)
      IDLE: begin
        // in_ready is constant-high here, so in_valid alone is the accept.
        if (in_valid) begin
          sa_d    = WIDTH'(sign_flip(CMP_MAX_WIDTH'(a), WIDTH));
          sb_d    = WIDTH'(sign_flip(CMP_MAX_WIDTH'(b), WIDTH));
          cnt_d   = '0;
          flag_d  = 1'b1;
          state_d = RUN;
`ifdef SIGNED_GEQ_EQ_OUT_EN
          all_eq_d = 1'b1;
`endif
        end
      end

      RUN: begin
        flag_d = flag_upd;
        sa_d   = sa_q >> DIGIT;
        sb_d   = sb_q >> DIGIT;
        cnt_d  = cnt_q + CNT_W'(1);
`ifdef SIGNED_GEQ_EQ_OUT_EN
        all_eq_d = all_eq_upd;
`endif
        if (cnt_q == CNT_LAST) begin
          geq_d   = flag_upd;
          state_d = DONE;
`ifdef SIGNED_GEQ_EQ_OUT_EN
          eq_d = all_eq_upd;
`endif
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs, independent of the order the simulator runs blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      geq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      geq_q   <= geq_d;
    end
  end

`ifdef SIGNED_GEQ_EQ_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_eq_q <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      all_eq_q <= all_eq_d;
      eq_q     <= eq_d;
    end
  end

  assign eq = eq_q;
`endif

  // Handshake outputs decode straight from the state register, so an async
  // reset drops out_valid and raises in_ready without waiting for a clock.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign geq       = geq_q;

endmodule : signed_geq_serial
